// File: rtl/in1536_out128.sv
// in1536_out128: serialises wide AXI-Stream words into narrow beats,
// least-significant slice first, with constant tkeep and a tlast placed
// by a programmable frame length that is independent of word boundaries.
module in1536_out128 #(
    parameter int unsigned DWIDTH_IN  = 1536,
    parameter int unsigned DWIDTH_OUT = 128,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LEN_W-1:0]        frame_len,
    input  logic [DWIDTH_IN-1:0]    s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DWIDTH_OUT-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DWIDTH_OUT/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast
);

    localparam int unsigned RATIO  = DWIDTH_IN / DWIDTH_OUT;
    localparam int unsigned IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned KEEP_W = DWIDTH_OUT / 8;

    typedef enum logic {
        EMPTY     = 1'b0,
        SERIALISE = 1'b1
    } state_t;

    state_t                              state_q;
    logic [RATIO-1:0][DWIDTH_OUT-1:0]    data_q;
    logic [IDX_W-1:0]                    idx_q;
    logic [LEN_W-1:0]                    bcnt_q;
    logic [LEN_W-1:0]                    len_q;

    logic                                full;
    logic                                last_idx;
    logic                                in_hs;
    logic                                out_hs;
    logic                                tlast_c;
    logic [LEN_W-1:0]                    len_e;

    // Handshake, refill and frame-length decode
    assign full          = (state_q == SERIALISE);
    assign last_idx      = (idx_q == IDX_W'(RATIO - 1));
    assign s_axis_tready = !full | (m_axis_tready & last_idx);
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign out_hs        = full & m_axis_tready;
    // A frame length change only takes effect at the next frame start
    assign len_e         = (bcnt_q == '0) ? frame_len : len_q;
    assign tlast_c       = full & (len_e != '0) & (bcnt_q == (len_e - LEN_W'(1)));

    // Output beat selection; tkeep is always full width
    assign m_axis_tvalid = full;
    assign m_axis_tdata  = data_q[idx_q];
    assign m_axis_tlast  = tlast_c;
    assign m_axis_tkeep  = {KEEP_W{1'b1}};

    // Word holding register, sub-beat index and frame beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            len_q   <= '0;
        end else begin
            if (in_hs) begin
                // Also covers the back-to-back refill on the final beat
                data_q  <= s_axis_tdata;
                idx_q   <= '0;
                state_q <= SERIALISE;
            end else if (out_hs) begin
                if (last_idx) begin
                    idx_q   <= '0;
                    state_q <= EMPTY;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end

            if (out_hs) begin
                if (bcnt_q == '0) begin
                    len_q <= frame_len;
                end
                if (tlast_c) begin
                    bcnt_q <= '0;
                end else if (bcnt_q != '1) begin
                    // Saturates when frame length is zero
                    bcnt_q <= bcnt_q + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_in1536_out128.sv
// tb_in1536_out128: directed bench for the 1536->128 down-converter.
// Word slice k of a word carries {8{value}}, with value = base + global beat.
module tb_in1536_out128;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [15:0]    frame_len;
    logic [1535:0]  s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [127:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [15:0]    m_axis_tkeep;
    logic           m_axis_tlast;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] lfsr = 16'hace1;

    always #5 clk = ~clk;

    in1536_out128 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_len     (frame_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Single comparison point: counts vectors and reports miscompares
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat_val(input int v);
        return {8{16'(v)}};
    endfunction

    function automatic logic [1535:0] mk_word(input int v0);
        logic [1535:0] w;
        for (int k = 0; k < 12; k++) w[k*128 +: 128] = beat_val(v0 + k);
        return w;
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Feed nw words, collect up to limit beats and check every beat.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run(input string tag, input int nw, input int base, input int flen,
                       input bit bp, input int limit,
                       output int n_last, output int hs_cyc, output int first_cyc);
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        int   fpos = 0;
        bit   started = 0;
        bit   held = 0;
        logic [127:0] hd = '0;
        logic hl = 1'b0;
        n_last    = 0;
        hs_cyc    = -1;
        first_cyc = -1;
        frame_len = 16'(flen);
        while (got < limit && cyc < 2000) begin
            s_axis_tvalid = (sent < nw);
            s_axis_tdata  = mk_word(base + sent * 12);
            if (bp) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                m_axis_tready = lfsr[0];
            end else begin
                m_axis_tready = 1'b1;
            end
            @(negedge clk);
            if (held && m_axis_tvalid) begin
                chk({tag, "_stall_data"}, m_axis_tdata, hd);
                chk({tag, "_stall_last"}, 128'(m_axis_tlast), 128'(hl));
            end
            if (!bp && started) chk({tag, "_no_bubble"}, 128'(m_axis_tvalid), 128'(1));
            if (m_axis_tvalid) begin
                chk({tag, "_s_ready"}, 128'(s_axis_tready),
                    128'(((got % 12) == 11) && m_axis_tready));
            end
            held = m_axis_tvalid && !m_axis_tready;
            hd   = m_axis_tdata;
            hl   = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                if (!started) first_cyc = cyc;
                started = 1;
                chk({tag, "_data"}, m_axis_tdata, beat_val(base + got));
                chk({tag, "_last"}, 128'(m_axis_tlast), 128'((flen != 0) && (fpos == flen - 1)));
                chk({tag, "_keep"}, 128'(m_axis_tkeep), 128'(16'hffff));
                if (m_axis_tlast) n_last++;
                fpos = ((flen != 0) && (fpos == flen - 1)) ? 0 : fpos + 1;
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (sent == 0) hs_cyc = cyc;
                sent++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        chk({tag, "_beat_count"}, 128'(got), 128'(limit));
    endtask

    initial begin
        int nl, hc, fc;
        frame_len = 16'd12;
        do_reset();

        // Reset state, with a non-zero frame length that must not leak into tlast
        @(negedge clk);
        chk("rst_valid", 128'(m_axis_tvalid), 128'(0));
        chk("rst_ready", 128'(s_axis_tready), 128'(1));
        chk("rst_data",  m_axis_tdata, 128'(0));
        chk("rst_last",  128'(m_axis_tlast), 128'(0));
        chk("rst_keep",  128'(m_axis_tkeep), 128'(16'hffff));
        @(posedge clk);
        #1;

        // Single word, frame of 12
        run("single", 1, 0, 12, 1'b0, 12, nl, hc, fc);
        chk("single_nlast", 128'(nl), 128'(1));
        chk("single_latency", 128'(fc), 128'(hc + 1));

        // Four words back to back
        do_reset();
        run("stream", 4, 100, 12, 1'b0, 48, nl, hc, fc);
        chk("stream_nlast", 128'(nl), 128'(4));

        // Random backpressure over three words
        do_reset();
        run("bp", 3, 500, 12, 1'b1, 36, nl, hc, fc);
        chk("bp_nlast", 128'(nl), 128'(3));

        // Frame of 5 across two words: tlast on beats 4, 9, 14, 19
        do_reset();
        run("len5", 2, 1000, 5, 1'b0, 24, nl, hc, fc);
        chk("len5_nlast", 128'(nl), 128'(4));

        // Frame length 0 never asserts tlast; frame length 1 asserts it every beat
        do_reset();
        run("len0", 2, 2000, 0, 1'b0, 24, nl, hc, fc);
        chk("len0_nlast", 128'(nl), 128'(0));
        do_reset();
        run("len1", 2, 3000, 1, 1'b0, 24, nl, hc, fc);
        chk("len1_nlast", 128'(nl), 128'(24));

        // Reset after beat 6 of a word
        do_reset();
        run("pre_rst", 1, 4000, 12, 1'b0, 7, nl, hc, fc);
        chk("pre_rst_valid", 128'(m_axis_tvalid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(m_axis_tvalid), 128'(0));
        chk("mid_rst_ready", 128'(s_axis_tready), 128'(1));
        chk("mid_rst_data",  m_axis_tdata, 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 128'(m_axis_tvalid), 128'(0));
        end
        @(posedge clk);
        #1;
        run("post_rst", 1, 5000, 12, 1'b0, 12, nl, hc, fc);
        chk("post_rst_nlast", 128'(nl), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/in1536_out128.md
# in1536_out128

Width down-converter closing the return path of the data route: takes 1536-bit AXI-Stream words from the wide switch fabric and serialises them into 128-bit beats for the narrow DMA-side ports (d/e). It is the inverse of the 128→1536 up-converter on the input side. It also generates the AXI-Stream `tkeep` and `tlast` sideband, with `tlast` placed by a programmable frame length.

## Interface
- `DWIDTH_IN`, default 1536: input word width.
- `DWIDTH_OUT`, default 128: output beat width. `RATIO = DWIDTH_IN/DWIDTH_OUT` is 12; `DWIDTH_IN` must be an exact multiple of `DWIDTH_OUT`.
- `LEN_W`, default 16: width of `frame_len`.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `frame_len`, in, LEN_W: output beats per frame. 0 means `tlast` is never asserted.
- `s_axis_tdata`, in, DWIDTH_IN: wide input word.
- `s_axis_tvalid`, in, 1: input valid.
- `s_axis_tready`, out, 1: input ready.
- `m_axis_tdata`, out, DWIDTH_OUT: narrow output beat.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: output ready.
- `m_axis_tkeep`, out, DWIDTH_OUT/8: byte enables, all ones.
- `m_axis_tlast`, out, 1: last beat of frame.

## Operation
- **Storage.** One DWIDTH_IN holding register `buf`, a `full` flag, a sub-beat index `idx` (0..RATIO-1) and a frame beat counter `bcnt` (LEN_W bits).
- **States.** EMPTY (`full`=0) and SERIALISE (`full`=1).
  - EMPTY → SERIALISE on an input handshake.
  - SERIALISE → EMPTY on the output handshake with `idx`=RATIO-1, unless a new input handshake happens in the same cycle.
- **Ready.** `s_axis_tready = !full | (m_axis_tready & idx==RATIO-1)`, combinational. This back-to-back refill gives zero bubbles between words.
- **Load.** On an input handshake: `buf` ← `s_axis_tdata`, `idx` ← 0, `full` ← 1.
- **Beat order.** Least-significant slice first. Beat k carries `buf[128k+127:128k]`, so beat 0 = bits [127:0] and beat 11 = bits [1535:1408].
- **Output valid and data.**
  - `m_axis_tvalid = full`.
  - `m_axis_tdata` is the slice selected by `idx`; a shift register or mux is allowed.
  - Data is stable while valid is high and ready is low.
- **Advance.** On an output handshake `idx` increments. At RATIO-1 it wraps to 0 and `full` clears, unless a refill occurs in the same cycle.
- **Frame length.**
  - Sampled into `len_q` on each output handshake with `bcnt`=0.
  - Effective length `len_e = (bcnt==0) ? frame_len : len_q`.
  - `m_axis_tlast = full & len_e!=0 & bcnt==len_e-1`.
  - On an output handshake, `bcnt` ← 0 if `tlast`, else `bcnt`+1.
  - With `len_e`=0, `bcnt` never wraps to 0 and saturates at all-ones.
  - Frames are independent of word boundaries: `tlast` may fall mid-word, and the rest of that word starts the next frame.
- **`tkeep`.** Constant all ones: 16'hffff at the default widths.
- **Unsupported condition.** A change of `frame_len` mid-frame has no effect until the next frame start.

## Timing
- **Reset values** (async assertion, takes effect immediately):
  - `full`=0, `idx`=0, `bcnt`=0, `len_q`=0, `buf`=0.
  - Outputs: `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tkeep`=all ones, `s_axis_tready`=1.
- **Latency.** Input handshake at cycle N → first beat valid at N+1.
- **Throughput.** One output beat per cycle under continuous ready. An input word is accepted every 12 cycles with no gaps.
- **Backpressure.** `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` hold while `m_axis_tready`=0. No input is accepted while holding beat 11 under backpressure.
- **Simultaneous events.** A final-beat output handshake and an input handshake in the same cycle reload `buf` and reset `idx` to 0. `full` stays 1.
- **Reset mid-word.** Remaining beats are discarded, frame position returns to 0, and no beat is emitted after `rst_n` rises until a new input is accepted.

## Test plan
- **Single word.** Load word with slice k = {8{k[15:0]}}, `frame_len`=12, `m_axis_tready`=1 → 12 beats on consecutive cycles starting 1 cycle after the handshake, values 0..11 in order. `tlast` only on beat 11. `tkeep`=16'hffff on every beat.
- **Streaming.** 4 words back-to-back, ready held high → 48 consecutive valid beats, no bubbles. `s_axis_tready` high exactly in cycles where `idx`=11.
- **Backpressure.** Toggle `m_axis_tready` with a pseudo-random pattern (50%) over 3 words → beat sequence identical to the unstalled run. Data and last are stable during every stall. No words are lost or duplicated.
- **Frame not aligned to words.** `frame_len`=5 over 2 words → `tlast` on global beats 4, 9, 14, 19. Beats 20–23 are the start of a frame with `bcnt` ending at 3.
- **`frame_len`=0 and `frame_len`=1.** With 0 → `tlast` never asserted over 24 beats. With 1 → `tlast` on every beat.
- **Reset during word.** Assert `rst_n`=0 after beat 6 of a word → `m_axis_tvalid` drops immediately and `s_axis_tready`=1. After release, the next word starts again at slice 0 with `bcnt`=0.
